rr_burst_arbiter: RTL and testbench
===================================

Name: rr_burst_arbiter

Overview:
- Registered round-robin arbiter with burst locking, sharing one resource among N requesters.
- A winner keeps the grant while its request stays high, up to MAX_HOLD consecutive cycles. The grant then rotates to the next requester in round-robin order.
- Within each search window the lowest index wins, using the isolate-lowest-set-bit scheme (req & ~(req-1)) already used by the team's combinational arbiters.
- Sits in front of shared buses and memories where requesters issue multi-beat transfers.

Parameters:
- N, 8, number of requesters (N >= 2).
- MAX_HOLD, 4, maximum consecutive cycles one requester holds the grant (>= 1; 1 gives plain per-cycle round-robin).

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  request vector, one bit per requester, level-sensitive.
- grant  output  N  registered one-hot grant, or all zeros.
- grant_valid  output  1  high when any grant bit is set.
- grant_id  output  clog2(N)  binary index of the granted requester; 0 when grant_valid=0.

Behaviour:
- Reset (async, rst=1):
  - grant=0, grant_valid=0, grant_id=0.
  - Internal: state=IDLE, priority pointer ptr=0, hold_cnt=0.
  - Outputs clear immediately on rst assertion, not at the next edge.
- All outputs are registered, with 1-cycle latency from sampled req to grant.
- Arbitration function pick(req, ptr):
  - m = req & {bits with index >= ptr}.
  - If m != 0, winner = lowest set bit of m.
  - Else winner = lowest set bit of req.
  - If req = 0, no winner.
- State IDLE (grant=0):
  - If req != 0: next state GRANT, owner w = pick(req, ptr), grant <= onehot(w), hold_cnt <= 1, ptr <= (w+1) mod N.
  - Else: stay IDLE.
- State GRANT (owner w), evaluated each edge in priority order:
  1. req[w]=0 and other requests pending: rearbitrate with pick(req, ptr); the new grant appears next cycle with no idle gap; hold_cnt <= 1; ptr advances past the new winner.
  2. req[w]=0 and req=0: go to IDLE, grant <= 0. ptr unchanged.
  3. req[w]=1 and hold_cnt = MAX_HOLD: rearbitrate with pick(req, ptr). Because ptr already points past w, w wins again only if it is the sole requester. In that case grant stays asserted with no gap and hold_cnt <= 1.
  4. Otherwise: keep grant, hold_cnt <= hold_cnt+1.
- Pointer wrap: winner N-1 gives ptr = 0.
- Counter width: hold_cnt is clog2(MAX_HOLD+1) bits and never exceeds MAX_HOLD.
- Invariants:
  - grant is always one-hot or zero.
  - grant_valid = |grant.
  - grant_id is consistent with grant.
  - No requester with req held continuously waits more than (N-1)*MAX_HOLD+1 cycles.
- Requests newly asserted while a burst is held do not preempt the owner.
- Reset mid-burst: the grant drops at once. After release, arbitration restarts from ptr=0.

Test Plan (N=4, MAX_HOLD=3):
- Reset behaviour: rst=1 with req=1111 -> grant=0000, grant_valid=0, grant_id=0. After release: grant=0001 one cycle later.
- Single requester: req=0001 constant -> grant=0001 every cycle from cycle 1, with no gap at each 3-cycle expiry; grant_id=0.
- Full contention: req=1111 constant -> grant sequence 0001x3, 0010x3, 0100x3, 1000x3, 0001x3, ...; grant_id follows 0,1,2,3.
- Early release: req=0011 gives grant=0001. Drop req[0] after 1 granted cycle -> next cycle grant=0010, hold_cnt restarts (0010 held 3 cycles if req[1] stays).
- Wrap-around: owner 3 reaches expiry with req=1001 -> next grant=0001, then after 3 cycles 1000. Separately: req=0000 after owner 2 -> grant=0000, grant_valid=0.
- Async reset mid-burst: assert rst between edges while grant=0100 -> grant=0000 immediately. Release with req=0110 -> grant=0010 (ptr restarted at 0).

Source files
------------

// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_burst_arbiter
// Purpose  : Registered round-robin arbiter with burst locking up to MAX_HOLD.
// Revision : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter #(
    parameter int N        = 8,
    parameter int MAX_HOLD = 4,
    localparam int c_idw   = $clog2(N),
    localparam int c_cw    = $clog2(MAX_HOLD + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    output logic [N-1:0]     grant,
    output logic             grant_valid,
    output logic [c_idw-1:0] grant_id
);

    localparam logic [c_cw-1:0] c_max_hold = c_cw'(MAX_HOLD);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_grant;
    logic               r_valid;
    logic [c_idw-1:0]   r_id;
    logic [c_idw-1:0]   r_ptr;
    logic [c_cw-1:0]    r_hold;

    logic [N-1:0]       w_mask;
    logic [N-1:0]       w_masked;
    logic [N-1:0]       w_cand;
    logic [N-1:0]       w_pick_oh;
    logic [c_idw-1:0]   w_pick_id;
    logic [c_idw-1:0]   w_next_ptr;
    logic               w_own_req;
    logic               w_rearb;

    // Search from ptr upward first; fall back to the whole vector on wrap.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < N; i++) begin
            w_mask[i] = (i >= int'(r_ptr));
        end
        w_masked  = req & w_mask;
        w_cand    = (|w_masked) ? w_masked : req;
        w_pick_oh = w_cand & ~(w_cand - N'(1));
        w_pick_id = '0;
        for (int i = 0; i < N; i++) begin
            if (w_pick_oh[i]) begin
                w_pick_id = c_idw'(i);
            end
        end
        w_next_ptr = (int'(w_pick_id) == N - 1) ? '0 : w_pick_id + c_idw'(1);
        w_own_req  = |(req & r_grant);
        w_rearb    = ((r_state == ST_IDLE) && (|req)) ||
                     ((r_state == ST_GRANT) &&
                      ((!w_own_req && (|req)) || (w_own_req && (r_hold == c_max_hold))));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_valid <= 1'b0;
            r_id    <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else if (w_rearb) begin
            r_state <= ST_GRANT;
            r_grant <= w_pick_oh;
            r_valid <= 1'b1;
            r_id    <= w_pick_id;
            r_ptr   <= w_next_ptr;
            r_hold  <= c_cw'(1);
        end else if (r_state == ST_GRANT) begin
            if (!w_own_req) begin
                // Owner released with nobody waiting: idle, pointer kept.
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_valid <= 1'b0;
                r_id    <= '0;
                r_hold  <= '0;
            end else begin
                r_hold  <= r_hold + c_cw'(1);
            end
        end
    end

    assign grant       = r_grant;
    assign grant_valid = r_valid;
    assign grant_id    = r_id;

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_burst_arbiter
// Purpose  : Scoreboard bench for rr_burst_arbiter (N=4, MAX_HOLD=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_burst_arbiter;

    localparam int c_n    = 4;
    localparam int c_hold = 3;

    logic           clk;
    logic           rst;
    logic [c_n-1:0] req;
    logic [c_n-1:0] grant;
    logic           grant_valid;
    logic [1:0]     grant_id;

    rr_burst_arbiter #(.N(c_n), .MAX_HOLD(c_hold)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    typedef struct {
        int             idx;
        logic [c_n-1:0] g;
    } exp_t;

    exp_t q_exp[$];
    int   n_vec = 0;
    int   n_err = 0;
    int   n_push = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] oh2id(input logic [c_n-1:0] g);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < c_n; i++) if (g[i]) r = 2'(i);
        return r;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    // Apply req at the falling edge; the grant it produces follows the next rising edge.
    task automatic apply(input logic [c_n-1:0] r, input logic [c_n-1:0] g);
        exp_t e;
        @(negedge clk);
        req  = r;
        e.idx = n_push;
        e.g   = g;
        n_push++;
        q_exp.push_back(e);
    endtask

    // Monitor: the arbiter presents a grant every cycle after each rising edge.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q_exp.size() > 0) begin
            e = q_exp.pop_front();
            check("grant", e.idx, 32'(grant), 32'(e.g));
            check("grant_valid", e.idx, 32'(grant_valid), 32'(|e.g));
            check("grant_id", e.idx, 32'(grant_id), 32'(oh2id(e.g)));
        end
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst = 1'b1;
        req = 4'b1111;
        repeat (2) @(posedge clk);
        #2;
        check("rst_grant", -1, 32'(grant), 32'h0);
        check("rst_valid", -1, 32'(grant_valid), 32'h0);
        check("rst_id", -1, 32'(grant_id), 32'h0);

        // Release reset with full contention: ptr=0 so requester 0 first.
        @(negedge clk);
        rst = 1'b0;
        e.idx = n_push; e.g = 4'b0001; n_push++;
        q_exp.push_back(e);
        apply(4'b1111, 4'b0001);
        apply(4'b1111, 4'b0001);
        repeat (3) apply(4'b1111, 4'b0010);
        repeat (3) apply(4'b1111, 4'b0100);
        repeat (3) apply(4'b1111, 4'b1000);
        repeat (3) apply(4'b1111, 4'b0001);

        // Idle, then a lone requester keeps its grant across expiries.
        apply(4'b0000, 4'b0000);
        repeat (7) apply(4'b0001, 4'b0001);

        // Early release hands over with no gap and a fresh hold count.
        apply(4'b0011, 4'b0001);
        apply(4'b0010, 4'b0010);
        apply(4'b0010, 4'b0010);
        apply(4'b0010, 4'b0010);
        apply(4'b0011, 4'b0001);
        apply(4'b0011, 4'b0001);

        // Wrap-around from requester 3 back to 0 and onward.
        apply(4'b1000, 4'b1000);
        apply(4'b1000, 4'b1000);
        apply(4'b1001, 4'b1000);
        apply(4'b1001, 4'b0001);
        apply(4'b1001, 4'b0001);
        apply(4'b1001, 4'b0001);
        apply(4'b1001, 4'b1000);

        // Owner 2 releases with nothing pending.
        apply(4'b0100, 4'b0100);
        apply(4'b0000, 4'b0000);
        apply(4'b0000, 4'b0000);
        apply(4'b0101, 4'b0001);

        // Reach owner 2, then hit reset between edges.
        apply(4'b0100, 4'b0100);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_grant", -2, 32'(grant), 32'h0);
        check("async_valid", -2, 32'(grant_valid), 32'h0);
        check("async_id", -2, 32'(grant_id), 32'h0);

        @(negedge clk);
        rst = 1'b0;
        req = 4'b0110;
        e.idx = n_push; e.g = 4'b0010; n_push++;
        q_exp.push_back(e);
        apply(4'b0110, 4'b0010);
        apply(4'b0110, 4'b0010);
        apply(4'b0110, 4'b0100);

        for (int k = 0; k < 10 && q_exp.size() > 0; k++) @(posedge clk);
        #3;
        if (q_exp.size() != 0) begin
            n_vec++;
            n_err++;
            $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
